// File: rtl/phase_signal_generator.sv
// Phase signal generator: REF/MES square-wave pair with programmable period
// and signed phase offset. New configurations are held in shadow registers
// and take effect only at a period boundary, or on the next cycle while the
// generator is disabled.
module phase_signal_generator #(
    parameter int WIDTH          = 32,
    parameter int DEFAULT_PERIOD = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_delay,
    input  logic             cfg_sign,
    input  logic             cfg_load,
    output logic             cfg_busy,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             REF,
    output logic             MES
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

    cfg_state_t       state_q;
    cfg_state_t       state_d;

    // Active configuration, drives the waveforms
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_delay;
    logic             act_sign;

    // Shadow configuration, waits for the next period boundary
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] sh_delay;
    logic             sh_sign;

    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] half;
    logic             load_ok;
    logic             wrap;
    logic             apply;

    // MES is high when the phase shifted by the effective delay falls in the
    // first half of the period. The shift wraps with a compare-and-add rather
    // than a modulo, using one extra bit so P-D and ph+P-d_eff never overflow.
    function automatic logic mes_high(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] per,
        input logic [WIDTH-1:0] dly,
        input logic             sgn,
        input logic [WIDTH-1:0] hlf
    );
        logic [WIDTH:0] d_eff;
        logic [WIDTH:0] m;
        if (sgn && (dly != '0))
            d_eff = {1'b0, per} - {1'b0, dly};
        else
            d_eff = {1'b0, dly};
        if ({1'b0, p} >= d_eff)
            m = {1'b0, p} - d_eff;
        else
            m = {1'b0, p} + {1'b0, per} - d_eff;
        return (m < {1'b0, hlf});
    endfunction

    assign half     = act_period >> 1;
    assign load_ok  = cfg_load && (cfg_period >= WIDTH'(4)) && (cfg_delay < cfg_period);
    assign wrap     = (ph == act_period - WIDTH'(1));
    assign apply    = (state_q == PEND) && (!enable || wrap);
    assign cfg_busy = (state_q == PEND);

    // Config state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Config next state: a new valid load always (re)enters PEND, even when
    // the old shadow is being applied in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_ok) state_d = PEND;
            PEND: begin
                if (load_ok)
                    state_d = PEND;
                else if (apply)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow capture on every accepted load; last load wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_period <= WIDTH'(DEFAULT_PERIOD);
            sh_delay  <= '0;
            sh_sign   <= 1'b0;
        end else if (load_ok) begin
            sh_period <= cfg_period;
            sh_delay  <= cfg_delay;
            sh_sign   <= cfg_sign;
        end
    end

    // Active config and phase counter; apply restarts the period at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_period <= WIDTH'(DEFAULT_PERIOD);
            act_delay  <= '0;
            act_sign   <= 1'b0;
            ph         <= '0;
        end else if (apply) begin
            act_period <= sh_period;
            act_delay  <= sh_delay;
            act_sign   <= sh_sign;
            ph         <= '0;
        end else if (enable) begin
            ph <= wrap ? '0 : ph + WIDTH'(1);
        end else begin
            ph <= '0;
        end
    end

    // Registered waveforms and status pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            REF     <= 1'b0;
            MES     <= 1'b0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            REF     <= enable && (ph < half);
            MES     <= enable && mes_high(ph, act_period, act_delay, act_sign, half);
            cfg_ack <= apply;
            cfg_err <= cfg_load && !load_ok;
        end
    end

endmodule

// File: tb/tb_phase_signal_generator.sv
// Directed testbench for phase_signal_generator.
module tb_phase_signal_generator;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] cfg_period = '0;
    logic [WIDTH-1:0] cfg_delay = '0;
    logic             cfg_sign = 1'b0;
    logic             cfg_load = 1'b0;
    logic             cfg_busy;
    logic             cfg_ack;
    logic             cfg_err;
    logic             REF;
    logic             MES;

    int checks = 0;
    int errors = 0;
    logic r_prev = 1'b0;
    logic m_prev = 1'b0;

    phase_signal_generator #(.WIDTH(WIDTH), .DEFAULT_PERIOD(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cfg_period (cfg_period),
        .cfg_delay  (cfg_delay),
        .cfg_sign   (cfg_sign),
        .cfg_load   (cfg_load),
        .cfg_busy   (cfg_busy),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .REF        (REF),
        .MES        (MES)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Advance one cycle, remembering the previous output samples
    task automatic tick();
        r_prev = REF;
        m_prev = MES;
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int p, input int d, input bit s);
        cfg_period = WIDTH'(p);
        cfg_delay  = WIDTH'(d);
        cfg_sign   = s;
        cfg_load   = 1'b1;
        tick();
        cfg_load   = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (!cfg_ack && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Sync to a REF rising edge (skipping the current one), then record one
    // window of p cycles: REF high/low counts, MES high count, MES rise offset,
    // and whether REF rises again exactly p cycles later.
    task automatic measure(input int p, output int hi, output int lo,
                           output int mhi, output int moff, output bit ok);
        int n;
        hi = 0; lo = 0; mhi = 0; moff = -1; ok = 1'b0;
        tick();
        tick();
        n = 0;
        while (!(REF && !r_prev) && n < 64) begin
            tick();
            n++;
        end
        if (n < 64) begin
            for (int i = 0; i < p; i++) begin
                if (MES && !m_prev && moff < 0) moff = i;
                if (REF) hi++; else lo++;
                if (MES) mhi++;
                tick();
            end
            ok = REF && !r_prev;
        end
    endtask

    task automatic check_wave(input string name, input int p, input int ehi,
                              input int emhi, input int emoff);
        int hi, lo, mhi, moff;
        bit ok;
        measure(p, hi, lo, mhi, moff, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_period got %0d exp 1 (hi=%0d lo=%0d)", name, ok, hi, lo);
        end
        checks++;
        if (hi != ehi || lo != p - ehi) begin
            errors++;
            $display("FAIL %s_ref_duty got hi=%0d lo=%0d exp hi=%0d lo=%0d", name, hi, lo, ehi, p - ehi);
        end
        checks++;
        if (mhi != emhi || moff != emoff) begin
            errors++;
            $display("FAIL %s_mes got hi=%0d off=%0d exp hi=%0d off=%0d", name, mhi, moff, emhi, emoff);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({REF, MES, cfg_busy, cfg_ack, cfg_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", {REF, MES, cfg_busy, cfg_ack, cfg_err});
        end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        check_wave("default", 8, 4, 4, 0);
        checks++;
        if (cfg_busy !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL default_status got busy=%b err=%b exp 0 0", cfg_busy, cfg_err);
        end
    endtask

    // Load lands at ph=1 of an 8-cycle period; ack after the ph=7 edge
    task automatic test_apply_at_wrap();
        int n;
        do_load(10, 3, 1'b0);
        checks++;
        if (cfg_busy !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL load_busy got busy=%b err=%b exp 1 0", cfg_busy, cfg_err);
        end
        wait_ack(n);
        checks++;
        if (n != 6 || cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_latency got %0d exp 6", n);
        end
        checks++;
        if (cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_ack got %b exp 0", cfg_busy);
        end
        tick();
        checks++;
        if (cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse got %b exp 0", cfg_ack);
        end
        check_wave("p10_lag3", 10, 5, 5, 3);
    endtask

    task automatic test_sign();
        int n;
        do_load(10, 3, 1'b1);
        wait_ack(n);
        checks++;
        if (cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL sign1_ack got %b exp 1", cfg_ack);
        end
        check_wave("p10_lead3", 10, 5, 5, 7);
        do_load(10, 3, 1'b0);
        wait_ack(n);
        check_wave("p10_lag3_again", 10, 5, 5, 3);
    endtask

    task automatic test_reject();
        do_load(3, 0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_short got err=%b busy=%b exp 1 0", cfg_err, cfg_busy);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got %b exp 0", cfg_err);
        end
        do_load(10, 10, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_delay got err=%b busy=%b exp 1 0", cfg_err, cfg_busy);
        end
        check_wave("after_reject", 10, 5, 5, 3);
    endtask

    task automatic test_back_to_back();
        int n;
        int acks;
        do_load(9, 0, 1'b1);
        wait_ack(n);
        check_wave("p9_d0", 9, 4, 4, 0);
        do_load(12, 2, 1'b0);
        do_load(8, 1, 1'b1);
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            if (cfg_ack) acks++;
            tick();
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL double_load_acks got %0d exp 1", acks);
        end
        check_wave("p8_lead1", 8, 4, 4, 7);
    endtask

    task automatic test_enable();
        enable = 1'b0;
        tick();
        checks++;
        if (REF !== 1'b0 || MES !== 1'b0) begin
            errors++;
            $display("FAIL disabled_out got REF=%b MES=%b exp 0 0", REF, MES);
        end
        do_load(9, 2, 1'b0);
        checks++;
        if (cfg_busy !== 1'b1 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL disabled_pend got busy=%b ack=%b exp 1 0", cfg_busy, cfg_ack);
        end
        tick();
        checks++;
        if (cfg_ack !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL disabled_apply got ack=%b busy=%b exp 1 0", cfg_ack, cfg_busy);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (REF !== 1'b1 || MES !== 1'b0) begin
            errors++;
            $display("FAIL enable_start got REF=%b MES=%b exp 1 0", REF, MES);
        end
        check_wave("p9_lag2", 9, 4, 4, 2);
    endtask

    task automatic test_async_reset();
        do_load(10, 3, 1'b0);
        checks++;
        if (cfg_busy !== 1'b1 || REF !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got busy=%b REF=%b exp 1 1", cfg_busy, REF);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({REF, MES, cfg_busy, cfg_ack} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0000", {REF, MES, cfg_busy, cfg_ack});
        end
        tick();
        tick();
        reset = 1'b0;
        check_wave("post_reset", 8, 4, 4, 0);
        checks++;
        if (cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy got %b exp 0", cfg_busy);
        end
    endtask

    initial begin
        test_reset();
        test_apply_at_wrap();
        test_sign();
        test_reject();
        test_back_to_back();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
